ip_hdr_chksum_chk: RTL and testbench
====================================

Name: ip_hdr_chksum_chk

Overview:
- Streaming IPv4 header checksum verifier. It sits on the parser byte/word stream, after Ethernet framing and ahead of the UDP/Mold/ITCH parsers.
- Per frame, it finds the IP header at a fixed byte offset and reads header length from IHL. It accumulates the header as 16-bit words with RFC1071 ones-complement arithmetic, then pulses a pass/fail result.
- It is generalised over stream width (bytes per beat) and supports IPv4 options (IHL 5..15).

Parameters:
- DATA_BYTES, 1, bytes per beat; legal values 1, 2, 4; byte 0 is in the MSB lane [8*DATA_BYTES-1 -: 8].
- HDR_OFFSET, 14, byte index of the first IP header byte from frame start; must be even.
- ACC_W, 24, accumulator width; must be ≥ 21 (30 words × 0xFFFF).

Ports:
- clk  in  1  single clock
- rstN  in  1  synchronous, active-low reset
- dataValid  in  1  frame beat valid; a frame is a contiguous dataValid-high run
- data  in  8*DATA_BYTES  frame bytes, network order, MSB lane first
- chkDone  out  1  one-cycle pulse: result valid
- chkOk  out  1  valid with chkDone: folded sum == 0xFFFF and IHL legal
- chkSum  out  16  valid with chkDone: ~folded sum (0x0000 for a good header)
- badIhl  out  1  valid with chkDone: IHL < 5
- truncErr  out  1  one-cycle pulse: frame ended before header complete

Behaviour:
- Reset (rstN=0 at posedge clk): FSM→IDLE, byteCnt=0, acc=0, hdrLen=0. chkDone, chkOk, chkSum, badIhl, truncErr all reset to 0.
- Byte indexing: lane L of beat n has index n*DATA_BYTES+L. Header bytes are indices HDR_OFFSET .. HDR_OFFSET+hdrLen-1.
- Word placement: a header byte with even (index−HDR_OFFSET) goes to the high byte of a word; odd goes to the low byte.
- IHL source: the low nibble of byte HDR_OFFSET. hdrLen = 4*IHL, latched in the beat that carries that byte. Accumulation of that beat uses the freshly decoded length.
- Byte masking: bytes outside the header window contribute 0.
- FSM:
  - IDLE: on dataValid=1, enter SKIP/HDR according to the beat's index range. byteCnt counts from that beat.
  - SKIP: count beats until the beat containing HDR_OFFSET, then go to HDR.
  - HDR: acc += sum of masked words in the beat. When the last header byte is consumed, go to FOLD.
  - FOLD: two end-around-carry folds to 16 bits (via sub-module), 1 cycle, then go to REPORT.
  - REPORT: drive chkDone=1 for one cycle, then go to WAIT_END.
  - WAIT_END: ignore data until dataValid=0, then go to IDLE.
- Latency: chkDone asserts 2 cycles after the clock edge that sampled the last header beat.
- IHL<5: no accumulation. Go directly to REPORT next cycle with chkOk=0, badIhl=1, chkSum=0.
- dataValid=0 in SKIP or HDR: truncErr=1 for one cycle, no chkDone, go to IDLE, acc cleared.
- dataValid=0 then 1 on consecutive cycles: treated as frame end followed by a new frame start.
- A new frame cannot begin while in FOLD or REPORT, because dataValid must drop first. Input during FOLD/REPORT is treated as the tail of the current frame.
- Synchronous reset mid-frame: immediate return to IDLE. The rest of that frame is treated as a new frame only if dataValid stays high after rstN rises. The bench must drop dataValid across reset.
- Beats straddling the header end: the remaining lanes are masked.

Optional Feature:
- Macro: IP_HDR_CHKSUM_STATS_EN.
- Defined: adds outputs goodCnt[15:0] and badCnt[15:0], both reset to 0.
  - goodCnt increments on chkDone&chkOk.
  - badCnt increments on chkDone&~chkOk or on truncErr.
  - Both saturate at 0xFFFF; no wrap.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package pkg:
  - IPV4_MIN_IHL=5, IPV4_MAX_IHL=15, CHKSUM_GOOD=16'hFFFF.
  - ipChkStateType enum {IDLE,SKIP,HDR,FOLD,REPORT,WAIT_END}.
  - Existing ipHeaderType reused by the bench.
- Sub-module ones_comp_fold: combinational/registered fold of ACC_W→16 bits, two carry add-backs. It is reused later by the UDP checksum block.

Test Plan:
- Header 4500 0073 0000 4000 4011 B861 C0A8 0001 C0A8 00C7 at offset 14, DATA_BYTES=1 → chkDone 2 cycles after the last byte, chkOk=1, chkSum=0x0000, badIhl=0.
- Same header with byte 0x73 corrupted to 0x74 → chkOk=0, chkSum=0xFFFF−0x0001=0xFFFE (ones-complement diff).
- IHL=6 header with 4-byte option, checksum recomputed by ip_header_chksum_calc, DATA_BYTES=4 (offset 14 is mid-beat) → chkOk=1; option bytes included.
- First header byte 0x43 → chkDone, badIhl=1, chkOk=0; next frame with a valid header → chkOk=1.
- dataValid dropped after 10 header bytes → truncErr pulse, no chkDone; with IP_HDR_CHKSUM_STATS_EN, badCnt=1.
- rstN=0 mid-HDR, then a full valid frame → single chkDone with chkOk=1; with the stats macro, goodCnt=1 and badCnt=0.

Source files
------------

// File: rtl/ip_hdr_chksum_chk_pkg.sv
// Shared IPv4 checksum definitions: header field limits, checker FSM encoding
// and the IPv4 header layout used by producers and benches.
package ip_hdr_chksum_chk_pkg;

    localparam logic [3:0]  IPV4_MIN_IHL = 4'd5;
    localparam logic [3:0]  IPV4_MAX_IHL = 4'd15;
    localparam logic [15:0] CHKSUM_GOOD  = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SKIP     = 3'd1,
        HDR      = 3'd2,
        FOLD     = 3'd3,
        REPORT   = 3'd4,
        WAIT_END = 3'd5
    } ipChkStateType;

    typedef struct packed {
        logic [3:0]  version;
        logic [3:0]  ihl;
        logic [7:0]  tos;
        logic [15:0] totalLen;
        logic [15:0] id;
        logic [15:0] flagsFrag;
        logic [7:0]  ttl;
        logic [7:0]  protocol;
        logic [15:0] chksum;
        logic [31:0] srcAddr;
        logic [31:0] dstAddr;
    } ipHeaderType;

endpackage

// File: rtl/ip_hdr_chksum_chk_if.sv
// Frame stream in / checksum verdict out. Optional counters appear when
// IP_HDR_CHKSUM_STATS_EN is defined.
interface ip_hdr_chksum_chk_if #(
    parameter int DATA_BYTES = 1
);
    logic                    dataValid;
    logic [8*DATA_BYTES-1:0] data;
    logic                    chkDone;
    logic                    chkOk;
    logic [15:0]             chkSum;
    logic                    badIhl;
    logic                    truncErr;
`ifdef IP_HDR_CHKSUM_STATS_EN
    logic [15:0]             goodCnt;
    logic [15:0]             badCnt;
`endif

    modport master (
        output dataValid, data,
        input  chkDone, chkOk, chkSum, badIhl, truncErr
`ifdef IP_HDR_CHKSUM_STATS_EN
        , input goodCnt, badCnt
`endif
    );

    modport slave (
        input  dataValid, data,
        output chkDone, chkOk, chkSum, badIhl, truncErr
`ifdef IP_HDR_CHKSUM_STATS_EN
        , output goodCnt, badCnt
`endif
    );
endinterface

// File: rtl/ip_hdr_chksum_chk_fold.sv
// Ones-complement fold of a wide accumulator to 16 bits with two end-around
// carry add-backs; valid for ACC_W in 17..32.
module ones_comp_fold #(
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0] acc_i,
    output logic [15:0]      sum_o
);
    logic [16:0] s1;
    logic [15:0] s2;

    always_comb begin
        s1    = 17'(acc_i[15:0]) + 17'(acc_i[ACC_W-1:16]);
        s2    = s1[15:0] + 16'(s1[16]);
        sum_o = s2;
    end
endmodule

// File: rtl/ip_hdr_chksum_chk.sv
// Streaming IPv4 header checksum verifier (RFC1071). Define
// IP_HDR_CHKSUM_STATS_EN to add saturating good/bad frame counters.
module ip_hdr_chksum_chk
    import ip_hdr_chksum_chk_pkg::*;
#(
    parameter int DATA_BYTES = 1,
    parameter int HDR_OFFSET = 14,
    parameter int ACC_W      = 24
) (
    input  logic                 clk,
    input  logic                 rstN,
    ip_hdr_chksum_chk_if.slave   bus
);
    localparam int CNT_W = 16;

    localparam logic [2:0] ST_IDLE     = IDLE;
    localparam logic [2:0] ST_SKIP     = SKIP;
    localparam logic [2:0] ST_HDR      = HDR;
    localparam logic [2:0] ST_FOLD     = FOLD;
    localparam logic [2:0] ST_REPORT   = REPORT;
    localparam logic [2:0] ST_WAIT_END = WAIT_END;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] byteCnt_q, byteCnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [5:0]       hdrLen_q, hdrLen_d;
    logic             badPend_q, badPend_d;
    logic [15:0]      fold_q, fold_d;
    logic             chkDone_q, chkDone_d;
    logic             chkOk_q, chkOk_d;
    logic [15:0]      chkSum_q, chkSum_d;
    logic             badIhl_q, badIhl_d;
    logic             truncErr_q, truncErr_d;

    logic [7:0]       laneByte [DATA_BYTES];
    logic [CNT_W-1:0] laneIdx  [DATA_BYTES];
    logic [CNT_W-1:0] base, beatEnd, hdrEnd;
    logic             ihlSeen, hdrStarted, hdrDone;
    logic [3:0]       ihl;
    logic [5:0]       hdrLenCur;
    logic [ACC_W-1:0] beatSum;
    logic [15:0]      foldSum;

    ones_comp_fold #(.ACC_W(ACC_W)) u_fold (
        .acc_i (acc_q),
        .sum_o (foldSum)
    );

    // Per-beat decode: IHL capture, header window masking and word placement.
    // HDR_OFFSET is even, so absolute byte parity selects the high/low half.
    always_comb begin
        base    = (state_q == ST_IDLE) ? '0 : byteCnt_q;
        beatEnd = base + CNT_W'(DATA_BYTES);
        ihlSeen = 1'b0;
        ihl     = '0;
        for (int l = 0; l < DATA_BYTES; l++) begin
            laneByte[l] = bus.data[8*(DATA_BYTES-l)-1 -: 8];
            laneIdx[l]  = base + CNT_W'(l);
            if (laneIdx[l] == CNT_W'(HDR_OFFSET)) begin
                ihlSeen = 1'b1;
                ihl     = laneByte[l][3:0];
            end
        end
        hdrLenCur = ihlSeen ? {ihl, 2'b00} : hdrLen_q;
        hdrEnd    = CNT_W'(HDR_OFFSET) + CNT_W'(hdrLenCur);
        beatSum   = '0;
        for (int l = 0; l < DATA_BYTES; l++) begin
            if (laneIdx[l] >= CNT_W'(HDR_OFFSET) && laneIdx[l] < hdrEnd) begin
                beatSum = beatSum + (laneIdx[l][0] ? ACC_W'(laneByte[l])
                                                   : ACC_W'({laneByte[l], 8'h00}));
            end
        end
        hdrStarted = beatEnd > CNT_W'(HDR_OFFSET);
        hdrDone    = hdrStarted && (beatEnd >= hdrEnd);
    end

    always_comb begin
        state_d    = state_q;
        byteCnt_d  = byteCnt_q;
        acc_d      = acc_q;
        hdrLen_d   = hdrLen_q;
        badPend_d  = badPend_q;
        fold_d     = fold_q;
        chkDone_d  = 1'b0;
        chkOk_d    = chkOk_q;
        chkSum_d   = chkSum_q;
        badIhl_d   = badIhl_q;
        truncErr_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_SKIP, ST_HDR: begin
                if (bus.dataValid) begin
                    byteCnt_d = beatEnd;
                    if (ihlSeen) hdrLen_d = hdrLenCur;
                    if (ihlSeen && ihl < IPV4_MIN_IHL) begin
                        state_d   = ST_REPORT;
                        badPend_d = 1'b1;
                        acc_d     = '0;
                    end else if (hdrDone) begin
                        acc_d   = acc_q + beatSum;
                        state_d = ST_FOLD;
                    end else if (hdrStarted) begin
                        acc_d   = acc_q + beatSum;
                        state_d = ST_HDR;
                    end else begin
                        state_d = ST_SKIP;
                    end
                end else if (state_q != ST_IDLE) begin
                    // Frame ended before the header was complete.
                    truncErr_d = 1'b1;
                    state_d    = ST_IDLE;
                    acc_d      = '0;
                    byteCnt_d  = '0;
                    hdrLen_d   = '0;
                end
            end
            ST_FOLD: begin
                fold_d  = foldSum;
                state_d = ST_REPORT;
            end
            ST_REPORT: begin
                chkDone_d = 1'b1;
                chkOk_d   = !badPend_q && (fold_q == CHKSUM_GOOD);
                chkSum_d  = badPend_q ? 16'h0000 : ~fold_q;
                badIhl_d  = badPend_q;
                badPend_d = 1'b0;
                acc_d     = '0;
                byteCnt_d = '0;
                hdrLen_d  = '0;
                state_d   = ST_WAIT_END;
            end
            ST_WAIT_END: begin
                if (!bus.dataValid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q    <= ST_IDLE;
            byteCnt_q  <= '0;
            acc_q      <= '0;
            hdrLen_q   <= '0;
            badPend_q  <= 1'b0;
            fold_q     <= '0;
            chkDone_q  <= 1'b0;
            chkOk_q    <= 1'b0;
            chkSum_q   <= '0;
            badIhl_q   <= 1'b0;
            truncErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byteCnt_q  <= byteCnt_d;
            acc_q      <= acc_d;
            hdrLen_q   <= hdrLen_d;
            badPend_q  <= badPend_d;
            fold_q     <= fold_d;
            chkDone_q  <= chkDone_d;
            chkOk_q    <= chkOk_d;
            chkSum_q   <= chkSum_d;
            badIhl_q   <= badIhl_d;
            truncErr_q <= truncErr_d;
        end
    end

    assign bus.chkDone  = chkDone_q;
    assign bus.chkOk    = chkOk_q;
    assign bus.chkSum   = chkSum_q;
    assign bus.badIhl   = badIhl_q;
    assign bus.truncErr = truncErr_q;

`ifdef IP_HDR_CHKSUM_STATS_EN
    logic [15:0] goodCnt_q, badCnt_q;

    // Counters follow the registered result pulses and stick at all-ones.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            goodCnt_q <= '0;
            badCnt_q  <= '0;
        end else begin
            if (chkDone_q && chkOk_q && goodCnt_q != 16'hFFFF)
                goodCnt_q <= goodCnt_q + 16'd1;
            if (((chkDone_q && !chkOk_q) || truncErr_q) && badCnt_q != 16'hFFFF)
                badCnt_q <= badCnt_q + 16'd1;
        end
    end

    assign bus.goodCnt = goodCnt_q;
    assign bus.badCnt  = badCnt_q;
`endif

endmodule

// File: tb/tb_ip_hdr_chksum_chk.sv
// Scoreboard bench for ip_hdr_chksum_chk: 1-byte and 4-byte stream instances,
// directed cases then randomized frames against an RFC1071 reference model.
module tb_ip_hdr_chksum_chk;
    import ip_hdr_chksum_chk_pkg::*;

    localparam int OFS = 14;

    typedef logic [7:0] byte_t;
    typedef struct {
        bit          trunc;
        bit          bad;
        bit          ok;
        logic [15:0] sum;
        int          edgeNo;
    } exp_t;

    logic  clk = 1'b0;
    logic  rstN = 1'b0;
    int    cyc = 0;
    int    errors = 0;
    int    checks = 0;
    byte_t frm[$];
    exp_t  q1[$];
    exp_t  q4[$];
    int    good1 = 0, bad1 = 0, good4 = 0, bad4 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    ip_hdr_chksum_chk_if #(.DATA_BYTES(1)) bus1();
    ip_hdr_chksum_chk_if #(.DATA_BYTES(4)) bus4();

    ip_hdr_chksum_chk #(.DATA_BYTES(1), .HDR_OFFSET(OFS), .ACC_W(24)) dut1 (
        .clk(clk), .rstN(rstN), .bus(bus1)
    );
    ip_hdr_chksum_chk #(.DATA_BYTES(4), .HDR_OFFSET(OFS), .ACC_W(24)) dut4 (
        .clk(clk), .rstN(rstN), .bus(bus4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Folded 16-bit ones-complement sum of hlen header bytes in frm.
    function automatic logic [15:0] ip_header_chksum_calc(input int hlen);
        logic [31:0] s;
        s = 0;
        for (int k = 0; k < hlen; k += 2)
            s += {16'h0, frm[OFS+k], frm[OFS+k+1]};
        while (s[31:16] != 0)
            s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        return s[15:0];
    endfunction

    // Reference outcome of the (beat-padded) frame in frm.
    function automatic exp_t model(input int db, input int startEdge);
        exp_t e;
        int n, ihlv, hlen;
        logic [15:0] f;
        n = frm.size();
        e.trunc = 0; e.bad = 0; e.ok = 0; e.sum = 16'h0;
        if (n <= OFS) begin
            e.trunc = 1; e.edgeNo = startEdge + n / db;
            return e;
        end
        ihlv = int'(frm[OFS][3:0]);
        if (ihlv < 5) begin
            e.bad = 1; e.edgeNo = startEdge + OFS / db + 1;
            return e;
        end
        hlen = 4 * ihlv;
        if (n < OFS + hlen) begin
            e.trunc = 1; e.edgeNo = startEdge + n / db;
            return e;
        end
        f = ip_header_chksum_calc(hlen);
        e.ok = (f == 16'hFFFF);
        e.sum = ~f;
        e.edgeNo = startEdge + (OFS + hlen - 1) / db + 2;
        return e;
    endfunction

    task automatic build_frame(input int ihlField, input int payload);
        ipHeaderType h;
        logic [159:0] bits;
        logic [15:0] cs;
        int hlen;
        frm.delete();
        for (int i = 0; i < OFS; i++) frm.push_back(8'($urandom));
        hlen = (ihlField < 5) ? 20 : 4 * ihlField;
        h.version = 4'd4;          h.ihl = 4'(ihlField);
        h.tos = 8'($urandom);      h.totalLen = 16'(hlen + payload);
        h.id = 16'($urandom);      h.flagsFrag = 16'h4000;
        h.ttl = 8'($urandom);      h.protocol = 8'd17;
        h.chksum = 16'h0;          h.srcAddr = $urandom;
        h.dstAddr = $urandom;
        bits = h;
        for (int i = 0; i < 20; i++) frm.push_back(bits[159-8*i -: 8]);
        for (int i = 20; i < hlen; i++) frm.push_back(8'($urandom));
        if (ihlField >= 5) begin
            cs = ~ip_header_chksum_calc(hlen);
            frm[OFS+10] = cs[15:8];
            frm[OFS+11] = cs[7:0];
        end
        for (int i = 0; i < payload; i++) frm.push_back(8'($urandom));
    endtask

    // Streams frm on the chosen instance. With doReset, reset is asserted
    // (dataValid dropped) after rstBeat beats and no result is expected.
    task automatic send(input int db, input bit doReset, input int rstBeat);
        exp_t e;
        int nb;
        while (frm.size() % db != 0) frm.push_back(8'($urandom));
        nb = frm.size() / db;
        @(negedge clk);
        if (!doReset) begin
            e = model(db, cyc + 1);
            if (db == 1) begin
                q1.push_back(e);
                if (e.trunc || !e.ok) bad1++; else good1++;
            end else begin
                q4.push_back(e);
                if (e.trunc || !e.ok) bad4++; else good4++;
            end
        end
        for (int b = 0; b < nb; b++) begin
            if (doReset && b == rstBeat) break;
            if (db == 1) begin
                bus1.data = frm[b];
                bus1.dataValid = 1'b1;
            end else begin
                bus4.data = {frm[4*b], frm[4*b+1], frm[4*b+2], frm[4*b+3]};
                bus4.dataValid = 1'b1;
            end
            @(negedge clk);
        end
        bus1.dataValid = 1'b0;
        bus4.dataValid = 1'b0;
        if (doReset) begin
            rstN = 1'b0;
            repeat (2) @(negedge clk);
            rstN = 1'b1;
            good1 = 0; bad1 = 0; good4 = 0; bad4 = 0;
        end
        repeat (4 + $urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic check_stats();
`ifdef IP_HDR_CHKSUM_STATS_EN
        check("dut1_goodCnt", 32'(bus1.goodCnt), 32'(good1));
        check("dut1_badCnt",  32'(bus1.badCnt),  32'(bad1));
        check("dut4_goodCnt", 32'(bus4.goodCnt), 32'(good4));
        check("dut4_badCnt",  32'(bus4.badCnt),  32'(bad4));
`endif
    endtask

    task automatic observe(input int which, input logic done, input logic trunc,
                           input logic ok, input logic bad, input logic [15:0] sum);
        exp_t e;
        string p;
        p = $sformatf("dut%0d", which);
        if ((which == 1 && q1.size() == 0) || (which == 4 && q4.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected_output: got done=%0b trunc=%0b, required no output", p, done, trunc);
            return;
        end
        if (which == 1) e = q1.pop_front();
        else            e = q4.pop_front();
        check({p, "_truncErr"}, 32'(trunc), 32'(e.trunc));
        check({p, "_chkDone"},  32'(done),  32'(!e.trunc));
        check({p, "_latency_edge"}, 32'(cyc), 32'(e.edgeNo));
        if (!e.trunc) begin
            check({p, "_chkOk"},  32'(ok),  32'(e.ok));
            check({p, "_badIhl"}, 32'(bad), 32'(e.bad));
            check({p, "_chkSum"}, 32'(sum), 32'(e.sum));
        end
    endtask

    // Monitor: samples just after each active edge, independent of stimulus.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus1.chkDone || bus1.truncErr)
                observe(1, bus1.chkDone, bus1.truncErr, bus1.chkOk, bus1.badIhl, bus1.chkSum);
            if (bus4.chkDone || bus4.truncErr)
                observe(4, bus4.chkDone, bus4.truncErr, bus4.chkOk, bus4.badIhl, bus4.chkSum);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [159:0] known;
        int kind, ihlv, hlen, cut;
        bus1.dataValid = 1'b0; bus1.data = '0;
        bus4.dataValid = 1'b0; bus4.data = '0;
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dut1_chkDone",  32'(bus1.chkDone),  0);
        check("rst_dut1_chkOk",    32'(bus1.chkOk),    0);
        check("rst_dut1_chkSum",   32'(bus1.chkSum),   0);
        check("rst_dut1_badIhl",   32'(bus1.badIhl),   0);
        check("rst_dut1_truncErr", 32'(bus1.truncErr), 0);
        check("rst_dut4_chkDone",  32'(bus4.chkDone),  0);
        check("rst_dut4_chkOk",    32'(bus4.chkOk),    0);
        check("rst_dut4_chkSum",   32'(bus4.chkSum),   0);
        check("rst_dut4_badIhl",   32'(bus4.badIhl),   0);
        check("rst_dut4_truncErr", 32'(bus4.truncErr), 0);
        check_stats();
        rstN = 1'b1;
        repeat (2) @(negedge clk);

        // Known-good reference header, then the same with 0x73 -> 0x74.
        known = 160'h4500_0073_0000_4000_4011_B861_C0A8_0001_C0A8_00C7;
        for (int v = 0; v < 2; v++) begin
            frm.delete();
            for (int i = 0; i < OFS; i++) frm.push_back(8'($urandom));
            for (int i = 0; i < 20; i++) frm.push_back(known[159-8*i -: 8]);
            if (v == 1) frm[OFS+3] = 8'h74;
            send(1, 0, 0);
        end

        // IHL=6 with a 4-byte option on the 4-byte stream.
        build_frame(6, 4);
        send(4, 0, 0);

        // IHL 3 followed by a valid frame.
        build_frame(5, 0);
        frm[OFS] = 8'h43;
        send(1, 0, 0);
        build_frame(5, 6);
        send(1, 0, 0);

        // Frame cut after 10 header bytes.
        build_frame(5, 0);
        while (frm.size() > OFS + 10) void'(frm.pop_back());
        send(1, 0, 0);
        check_stats();

        // Reset in the middle of the header, then a full valid frame.
        build_frame(5, 4);
        send(1, 1, OFS + 6);
        build_frame(5, 4);
        send(1, 0, 0);
        check_stats();

        // Randomized frames on both stream widths.
        for (int db = 1; db <= 4; db += 3) begin
            for (int n = 0; n < 30; n++) begin
                kind = $urandom_range(0, 9);
                ihlv = $urandom_range(5, 15);
                hlen = 4 * ihlv;
                if (kind == 0) begin
                    build_frame($urandom_range(0, 4), $urandom_range(0, 7));
                end else begin
                    build_frame(ihlv, $urandom_range(0, 7));
                    if (kind == 1) begin
                        cut = $urandom_range(1, OFS + hlen - 1);
                        while (frm.size() > cut) void'(frm.pop_back());
                    end else if (kind == 2) begin
                        cut = OFS + $urandom_range(0, hlen - 1);
                        frm[cut] = frm[cut] ^ (8'h01 << $urandom_range(0, 7));
                    end
                end
                send(db, 0, 0);
            end
        end

        repeat (10) @(negedge clk);
        check("dut1_pending_results", 32'(q1.size()), 0);
        check("dut4_pending_results", 32'(q4.size()), 0);
        check_stats();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
